// File: rtl/acc_readout_buffer_pkg.sv
// Shared types and helpers for the accumulator readout buffer.
// Holds the reader FSM encoding and the saturating drop counter increment.
package acc_readout_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream
  } rd_state_e;

  localparam int unsigned DropCntW = 16;

  function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
    return (v == {DropCntW{1'b1}}) ? v : v + DropCntW'(1);
  endfunction

endpackage

// File: rtl/acc_readout_buffer_skid.sv
// Two-entry output register: the head drives the stream, the spare entry
// absorbs a word already in flight from the RAM when the consumer stalls.
module acc_readout_buffer_skid #(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       occupancy_o
);

  logic [Width-1:0] head_q, head_d, spare_q, spare_d;
  logic             head_v_q, head_v_d, spare_v_q, spare_v_d;
  logic             pop;

  assign pop = head_v_q && out_ready_i;

  always_comb begin
    head_d    = head_q;
    head_v_d  = head_v_q;
    spare_d   = spare_q;
    spare_v_d = spare_v_q;
    if (!head_v_q || pop) begin
      if (spare_v_q) begin
        head_d    = spare_q;
        head_v_d  = 1'b1;
        spare_v_d = in_valid_i;
        if (in_valid_i) begin
          spare_d = in_data_i;
        end
      end else begin
        head_v_d = in_valid_i;
        if (in_valid_i) begin
          head_d = in_data_i;
        end
      end
    end else if (in_valid_i) begin
      spare_d   = in_data_i;
      spare_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      head_v_q  <= 1'b0;
      spare_q   <= '0;
      spare_v_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      head_v_q  <= head_v_d;
      spare_q   <= spare_d;
      spare_v_q <= spare_v_d;
    end
  end

  assign out_valid_o = head_v_q;
  assign out_data_o  = head_q;
  assign occupancy_o = {1'b0, head_v_q} + {1'b0, spare_v_q};

endmodule

// File: rtl/sync_simple_dual_ram.sv
// Simple dual-port RAM: port a writes, port b reads with one cycle of latency
// in LOW_LATENCY mode and two cycles in HIGH_PERFORMANCE mode.
module sync_simple_dual_ram #(
  parameter int    RAM_WIDTH       = 64,
  parameter int    RAM_DEPTH       = 512,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                         clka,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         enb,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_q;

  always_ff @(posedge clka) begin
    if (wea) begin
      mem_q[addra] <= dina;
    end
  end

  always_ff @(posedge clka) begin
    if (enb) begin
      ram_data_q <= mem_q[addrb];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    logic unused_regceb;
    assign unused_regceb = regceb;
    assign doutb         = ram_data_q;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] dout_q;
    always_ff @(posedge clka) begin
      if (regceb) begin
        dout_q <= ram_data_q;
      end
    end
    assign doutb = dout_q;
  end

endmodule

// File: rtl/acc_readout_buffer.sv
// Double-buffered readout stage: captures accumulator frames into two RAM
// banks and replays them on a valid/ready stream, dropping frames on overrun.
module acc_readout_buffer
  import acc_readout_buffer_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 64,
  parameter int unsigned VECTOR_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 overflow,
  input  logic                 ovf_clear,
  output logic [15:0]          drop_count
);

  localparam int unsigned CntW  = $clog2(VECTOR_LEN);
  localparam int unsigned AddrW = CntW + 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(VECTOR_LEN - 1);
  localparam logic [CntW:0]   FrameLen = (CntW + 1)'(VECTOR_LEN);

  // Writer state
  logic [CntW-1:0]     in_cnt_q, in_cnt_d;
  logic                w_bank_q, w_bank_d;
  logic                dropping_q, dropping_d;
  logic [1:0]          full_q, full_d, full_avail;
  logic                overflow_q, overflow_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic                frame_start, drop_start, wr_en, frame_done;

  // Reader state
  rd_state_e           state_q;
  logic                r_bank_q;
  logic [CntW:0]       rd_cnt_q;
  logic                pend_q, pend_last_q;
  logic                rd_en, rd_last, room, pop, release_bank;
  logic [CntW-1:0]     rd_idx;
  logic [1:0]          release_mask, occupancy;
  logic [2:0]          load;
  logic [DIN_WIDTH-1:0] ram_rd_data;

  assign pop          = dout_valid && dout_ready;
  assign release_bank = pop && dout_last;
  assign release_mask = release_bank ? (2'b01 << r_bank_q) : 2'b00;

  // A release in the same cycle frees the bank for an arriving frame start.
  assign full_avail  = full_q & ~release_mask;
  assign frame_start = din_valid && (in_cnt_q == '0);
  assign drop_start  = frame_start && full_avail[w_bank_q];
  assign wr_en       = din_valid && (frame_start ? !full_avail[w_bank_q] : !dropping_q);
  assign frame_done  = wr_en && (in_cnt_q == LastIdx);

  always_comb begin
    full_d = full_avail;
    if (frame_done) begin
      full_d[w_bank_q] = 1'b1;
    end
    w_bank_d   = w_bank_q ^ frame_done;
    in_cnt_d   = din_valid ? in_cnt_q + CntW'(1) : in_cnt_q;
    dropping_d = frame_start ? drop_start : dropping_q;
    overflow_d = (overflow_q && !ovf_clear) || drop_start;
    drop_cnt_d = drop_start ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q   <= '0;
      w_bank_q   <= 1'b0;
      dropping_q <= 1'b0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      w_bank_q   <= w_bank_d;
      dropping_q <= dropping_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Issue a read only if the word can still land in the skid entries after
  // whatever is already held or in flight.
  assign load    = 3'(occupancy) + 3'(pend_q);
  assign room    = load <= (3'(pop) + 3'd1);
  assign rd_idx  = rd_cnt_q[CntW-1:0];
  assign rd_last = rd_idx == LastIdx;
  assign rd_en   = (state_q == StPrime) ||
                   ((state_q == StStream) && (rd_cnt_q != FrameLen) && room);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      r_bank_q    <= 1'b0;
      rd_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= rd_en;
      pend_last_q <= rd_last;
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + (CntW + 1)'(1);
      end
      unique case (state_q)
        StIdle: begin
          // Looking at full_d lets the prime read go out as full rises.
          if (full_d[r_bank_q]) begin
            state_q <= StPrime;
          end
        end
        StPrime: state_q <= StStream;
        StStream: begin
          if (release_bank) begin
            state_q  <= StIdle;
            r_bank_q <= ~r_bank_q;
            rd_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sync_simple_dual_ram #(
    .RAM_WIDTH      (DIN_WIDTH),
    .RAM_DEPTH      (2 * VECTOR_LEN),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_ram (
    .clka  (clk),
    .wea   (wr_en),
    .addra (AddrW'({w_bank_q, in_cnt_q})),
    .addrb (AddrW'({r_bank_q, rd_idx})),
    .dina  (din),
    .enb   (1'b1),
    .regceb(1'b1),
    .doutb (ram_rd_data)
  );

  acc_readout_buffer_skid #(
    .Width(DIN_WIDTH + 1)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (pend_q),
    .in_data_i  ({pend_last_q, ram_rd_data}),
    .out_valid_o(dout_valid),
    .out_data_o ({dout_last, dout}),
    .out_ready_i(dout_ready),
    .occupancy_o(occupancy)
  );

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_acc_readout_buffer.sv
// Directed bench for acc_readout_buffer with VECTOR_LEN=8: latency, ordering,
// stall stability, overrun drop, release/start collision and mid-frame reset.
module tb_acc_readout_buffer;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din;
  logic        din_valid;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        overflow;
  logic        ovf_clear;
  logic [15:0] drop_count;

  int          checks = 0;
  int          errors = 0;
  word_t       exp_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_dout;
  logic        prev_last;
  bit          found;

  acc_readout_buffer #(
    .DIN_WIDTH (64),
    .VECTOR_LEN(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, then advance past the rising edge.
  task automatic step();
    word_t w;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", 64'(dout_valid), 64'd1);
      chk("stall_data", dout, prev_dout);
      chk("stall_last", 64'(dout_last), 64'(prev_last));
    end
    if (dout_valid && dout_ready) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL extra_word: observed %0h expected no word", dout);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("out_data", dout, w.data);
        chk("out_last", 64'(dout_last), 64'(w.last));
      end
    end
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_last  = dout_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] base, input bit keep, input int nwords,
                            input bit clr_first);
    for (int i = 0; i < nwords; i++) begin
      din       = base + 64'(i);
      din_valid = 1'b1;
      ovf_clear = clr_first && (i == 0);
      if (keep) exp_q.push_back('{data: base + 64'(i), last: (i == 7)});
      step();
    end
    din_valid = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget, input bit rnd);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    dout_ready = 1'b1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    ovf_clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_last", 64'(dout_last), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    rst = 1'b0;
    step();

    // Single frame: first word valid three cycles after the last input word.
    send_frame(64'd1, 1'b1, 8, 1'b0);
    chk("t1_lat1", 64'(dout_valid), 64'd0);
    step();
    chk("t1_lat2", 64'(dout_valid), 64'd0);
    step();
    chk("t1_lat3", 64'(dout_valid), 64'd1);
    chk("t1_first", dout, 64'd1);
    repeat (8) step();
    chk("t1_contig", 64'(exp_q.size()), 64'd0);
    chk("t1_idle", 64'(dout_valid), 64'd0);
    chk("t1_ovf", 64'(overflow), 64'd0);

    // Back-to-back frames.
    send_frame(64'd1, 1'b1, 8, 1'b0);
    send_frame(64'd9, 1'b1, 8, 1'b0);
    drain("t2_drain", 60, 1'b0);
    chk("t2_ovf", 64'(overflow), 64'd0);

    // Gappy input with a randomly stalling consumer.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        din        = {$urandom(), $urandom()};
        din_valid  = 1'b1;
        dout_ready = 1'($urandom_range(0, 1));
        exp_q.push_back('{data: din, last: (i == 7)});
        step();
        din_valid  = 1'b0;
        dout_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    drain("t4_drain", 200, 1'b1);
    chk("t4_ovf", 64'(overflow), 64'd0);
    chk("t4_drops", 64'(drop_count), 64'd0);

    // Frame start on the same cycle the last word of the target bank is taken.
    dout_ready = 1'b0;
    send_frame(64'd101, 1'b1, 8, 1'b0);
    send_frame(64'd201, 1'b1, 8, 1'b0);
    dout_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (dout_valid && dout_last) found = 1'b1;
      else step();
    end
    chk("t5_found", 64'(found), 64'd1);
    send_frame(64'd301, 1'b1, 8, 1'b0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    drain("t5_drain", 60, 1'b0);
    chk("t5_drops", 64'(drop_count), 64'd0);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("t5_clr", 64'(overflow), 64'd0);

    // Overrun: third frame dropped while the consumer is stalled.
    dout_ready = 1'b0;
    send_frame(64'h8000_0000_0000_0001, 1'b1, 8, 1'b0);
    send_frame(64'hFFFF_FFFF_FFFF_FF00, 1'b1, 8, 1'b0);
    chk("t3_ovf_pre", 64'(overflow), 64'd0);
    send_frame(64'd501, 1'b0, 1, 1'b0);
    chk("t3_ovf_rise", 64'(overflow), 64'd1);
    chk("t3_drop1", 64'(drop_count), 64'd1);
    send_frame(64'd502, 1'b0, 7, 1'b0);
    chk("t3_drop_once", 64'(drop_count), 64'd1);
    drain("t3_drain", 80, 1'b0);
    repeat (4) step();
    chk("t3_no_extra", 64'(dout_valid), 64'd0);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("t3_clr", 64'(overflow), 64'd0);
    chk("t3_drops_kept", 64'(drop_count), 64'd1);

    // Clear coinciding with a drop, then reset in the middle of a frame.
    dout_ready = 1'b0;
    send_frame(64'd601, 1'b1, 8, 1'b0);
    send_frame(64'd701, 1'b1, 8, 1'b0);
    send_frame(64'd801, 1'b0, 8, 1'b0);
    chk("t6_ovf", 64'(overflow), 64'd1);
    chk("t6_drops2", 64'(drop_count), 64'd2);
    send_frame(64'd901, 1'b0, 3, 1'b1);
    chk("t6_clr_vs_drop", 64'(overflow), 64'd1);
    chk("t6_drops3", 64'(drop_count), 64'd3);
    chk("t6_pre_valid", 64'(dout_valid), 64'd1);
    din       = 64'd904;
    din_valid = 1'b1;
    rst       = 1'b1;
    #1;
    chk("t6_rst_dout", dout, 64'd0);
    chk("t6_rst_valid", 64'(dout_valid), 64'd0);
    chk("t6_rst_last", 64'(dout_last), 64'd0);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
    chk("t6_rst_drops", 64'(drop_count), 64'd0);
    din_valid = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    dout_ready = 1'b1;
    send_frame(64'hDEAD_0000_0000_0010, 1'b1, 8, 1'b0);
    drain("t6_drain", 40, 1'b0);
    chk("t6_ovf_after", 64'(overflow), 64'd0);
    chk("t6_drops_after", 64'(drop_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
